// File: rtl/updown_counter_pkg.sv
// Shared encodings for the up/down modulo counter: boundary mode and count direction.
package updown_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control and status bundle of the up/down modulo counter.
// There is no valid/ready handshake: the counter samples every control input on each rising clk edge.
interface updown_counter_mod_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             ud;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] limit;
    logic             clr_flags;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             unf;

    modport master (
        output en, ud, load, din, limit, clr_flags,
        input  count, tc, ovf, unf
    );

    modport slave (
        input  en, ud, load, din, limit, clr_flags,
        output count, tc, ovf, unf
    );
endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter (range 0..limit) with load, enable,
// wrap/saturate boundaries, a terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_mod
    import updown_counter_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               SATURATE = 0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input logic                 clk,
    input logic                 rst,
    updown_counter_mod_if.slave bus
);

    localparam logic MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_next_count;
    logic             w_up_evt;
    logic             w_dn_evt;

    // A count above a lowered limit counts as "at or past the top" when stepping up.
    always_comb begin
        w_next_count = r_count;
        w_up_evt     = 1'b0;
        w_dn_evt     = 1'b0;
        if (bus.load) begin
            w_next_count = (bus.din <= bus.limit) ? bus.din : bus.limit;
        end else if (bus.en) begin
            if (bus.ud == DIR_UP) begin
                if (r_count < bus.limit) begin
                    w_next_count = r_count + 1'b1;
                end else begin
                    w_up_evt     = 1'b1;
                    w_next_count = (MODE == MODE_SAT) ? bus.limit : '0;
                end
            end else begin
                if (r_count != '0) begin
                    w_next_count = r_count - 1'b1;
                end else begin
                    w_dn_evt     = 1'b1;
                    w_next_count = (MODE == MODE_SAT) ? '0 : bus.limit;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RST_VAL;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_tc    <= w_up_evt | w_dn_evt;
            // A new event outranks a same-cycle clear.
            if (w_up_evt)           r_ovf <= 1'b1;
            else if (bus.clr_flags) r_ovf <= 1'b0;
            if (w_dn_evt)           r_unf <= 1'b1;
            else if (bus.clr_flags) r_unf <= 1'b0;
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;

endmodule
